// File: rtl/moving_average_ctrl.sv
// moving_average_ctrl: flush, warm-up and decimation sequencer for a ce-gated 5-tap moving-average filter.
// Optional warm-up discard (FILL state) is enabled by defining MA_CTRL_WARMUP_EN.
module moving_average_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int DECIM = 4,
  parameter int WARMUP = 6,
  parameter int FLUSH_LEN = 6
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic                         flush,
  input  logic signed [DATA_WIDTH-1:0] s_tdata,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  output logic                         filt_ce,
  output logic signed [DATA_WIDTH-1:0] filt_din,
  input  logic signed [DATA_WIDTH-1:0] filt_dout,
  output logic signed [DATA_WIDTH-1:0] m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         busy
);
`ifdef MA_CTRL_WARMUP_EN
  typedef enum logic [1:0] {FLUSH, FILL, RUN} state_t;
`else
  typedef enum logic [1:0] {FLUSH, RUN} state_t;
`endif
  state_t state, state_n;
  logic [7:0] flush_cnt, flush_cnt_n, dec_cnt, dec_cnt_n;
`ifdef MA_CTRL_WARMUP_EN
  logic [7:0] warm_cnt, warm_cnt_n;
`endif
  logic pend, pend_n, m_tvalid_n, in_flush, acc, cap, dec_wrap;
  logic signed [DATA_WIDTH-1:0] m_tdata_n;
  // Reset is synchronous, so gate with aresetn to keep the filter flushing before the first edge.
  assign in_flush = !aresetn || state == FLUSH;
  assign s_tready = !in_flush && !flush && !pend && (!m_tvalid || m_tready);
  assign acc = s_tvalid && s_tready;
  assign filt_ce = in_flush || acc;
  assign filt_din = in_flush ? '0 : s_tdata;
  assign busy = in_flush;
  assign cap = pend && !flush;
  assign dec_wrap = dec_cnt == 8'(DECIM - 1);
  always_comb begin
    state_n = state;
    flush_cnt_n = flush_cnt;
    dec_cnt_n = dec_cnt;
`ifdef MA_CTRL_WARMUP_EN
    warm_cnt_n = warm_cnt;
`endif
    pend_n = 1'b0;
    m_tvalid_n = cap || (m_tvalid && !m_tready);
    m_tdata_n = cap ? filt_dout : m_tdata;
    case (state)
      FLUSH: begin
        flush_cnt_n = flush_cnt + 8'd1;
        if (flush_cnt == 8'(FLUSH_LEN - 1)) begin
          flush_cnt_n = '0;
`ifdef MA_CTRL_WARMUP_EN
          state_n = (WARMUP > 0) ? FILL : RUN;
`else
          state_n = RUN;
`endif
        end
      end
`ifdef MA_CTRL_WARMUP_EN
      FILL: if (acc) begin
        warm_cnt_n = warm_cnt + 8'd1;
        if (warm_cnt == 8'(WARMUP - 1)) state_n = RUN;
      end
`endif
      RUN: if (acc) begin
        pend_n = dec_wrap;
        dec_cnt_n = dec_wrap ? '0 : dec_cnt + 8'd1;
      end
      default: state_n = FLUSH;
    endcase
    // A held output survives a flush; only the uncaptured result is dropped.
    if (flush) begin
      state_n = FLUSH;
      flush_cnt_n = '0;
      dec_cnt_n = '0;
`ifdef MA_CTRL_WARMUP_EN
      warm_cnt_n = '0;
`endif
      pend_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state <= FLUSH;
      flush_cnt <= '0;
      dec_cnt <= '0;
`ifdef MA_CTRL_WARMUP_EN
      warm_cnt <= '0;
`endif
      pend <= 1'b0;
      m_tvalid <= 1'b0;
      m_tdata <= '0;
    end else begin
      state <= state_n;
      flush_cnt <= flush_cnt_n;
      dec_cnt <= dec_cnt_n;
`ifdef MA_CTRL_WARMUP_EN
      warm_cnt <= warm_cnt_n;
`endif
      pend <= pend_n;
      m_tvalid <= m_tvalid_n;
      m_tdata <= m_tdata_n;
    end
  end
endmodule

// File: tb/tb_moving_average_ctrl.sv
// tb_moving_average_ctrl: two controllers (DECIM=1 and DECIM=4) on shared stimulus, each driving a
// behavioural 5-tap filter; outputs are checked against a sample-history scoreboard.
module tb_moving_average_ctrl;
  localparam int DW = 16;
  localparam int DEC [2] = '{1, 4};
`ifdef MA_CTRL_WARMUP_EN
  localparam int W = 6;
`else
  localparam int W = 0;
`endif
  logic clk = 0, aresetn = 0, flush = 0, s_tvalid = 0, m_tready = 0;
  logic signed [DW-1:0] s_tdata = '0;
  logic s_tready [2], filt_ce [2], m_tvalid [2], busy [2];
  logic signed [DW-1:0] filt_din [2], filt_dout [2], m_tdata [2];
  int n_cmp = 0, n_mis = 0;
  int tap [2][6];
  int hist [2][$];
  logic signed [DW-1:0] sb [2][$];
  bit p1 [2], p2 [2], mvp [2];

  always #5 clk = ~clk;

  moving_average_ctrl #(.DATA_WIDTH(DW), .DECIM(1)) u0 (
    .clk(clk), .aresetn(aresetn), .flush(flush), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready[0]), .filt_ce(filt_ce[0]), .filt_din(filt_din[0]), .filt_dout(filt_dout[0]),
    .m_tdata(m_tdata[0]), .m_tvalid(m_tvalid[0]), .m_tready(m_tready), .busy(busy[0]));
  moving_average_ctrl #(.DATA_WIDTH(DW), .DECIM(4)) u1 (
    .clk(clk), .aresetn(aresetn), .flush(flush), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready[1]), .filt_ce(filt_ce[1]), .filt_din(filt_din[1]), .filt_dout(filt_dout[1]),
    .m_tdata(m_tdata[1]), .m_tvalid(m_tvalid[1]), .m_tready(m_tready), .busy(busy[1]));

  task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reset-less filter: output registers the rounded sum of the taps 2..6 ce cycles old.
  function automatic int tsum(int i);
    tsum = 0;
    for (int k = 1; k < 6; k++) tsum += tap[i][k];
  endfunction
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (filt_ce[i]) begin
        filt_dout[i] <= DW'((tsum(i) + 2) >>> 2);
        for (int k = 5; k > 0; k--) tap[i][k] <= tap[i][k-1];
        tap[i][0] <= int'(filt_din[i]);
      end

  // Expected value for the newest accepted sample: samples n-6..n-2 since flush, zeros before.
  function automatic logic signed [DW-1:0] expv(int i);
    int n = hist[i].size();
    int s = 0;
    for (int k = n - 6; k <= n - 2; k++) if (k >= 1) s += hist[i][k-1];
    return DW'((s + 2) >>> 2);
  endfunction

  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      if (!aresetn) begin
        sb[i].delete();
        hist[i].delete();
        p1[i] = 0;
        p2[i] = 0;
        mvp[i] = 0;
      end else begin
        if (m_tvalid[i] && m_tready) begin
          if (sb[i].size() == 0) check("unexpected_out", m_tvalid[i], 0);
          else check("out_data", m_tdata[i], sb[i].pop_front());
        end
        if (p2[i] || (m_tvalid[i] && !mvp[i])) check("out_latency", m_tvalid[i], p2[i]);
        if (flush) check("flush_blocks_ready", s_tready[i], 0);
        mvp[i] = m_tvalid[i];
        p2[i] = p1[i];
        p1[i] = 0;
        if (flush) begin
          if (p2[i]) void'(sb[i].pop_back());
          p2[i] = 0;
          hist[i].delete();
        end else if (s_tvalid && s_tready[i]) begin
          hist[i].push_back(int'(s_tdata));
          if (hist[i].size() > W && (hist[i].size() - W) % DEC[i] == 0) begin
            sb[i].push_back(expv(i));
            p1[i] = 1;
          end
        end
      end
    end

  task automatic flush_window();
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check("flush_busy", busy[i], k < 6);
        check("flush_din", filt_din[i], k < 6 ? 0 : 1000);
        if (k < 6) check("flush_ce", filt_ce[i], 1);
        check("flush_ready", s_tready[i], k >= 6);
      end
    end
  endtask

  initial begin
    logic prev;
    int w;
    s_tvalid = 1;
    s_tdata = 1000;
    m_tready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", busy[i], 1);
      check("rst_ready", s_tready[i], 0);
      check("rst_ce", filt_ce[i], 1);
      check("rst_din", filt_din[i], 0);
      check("rst_mvalid", m_tvalid[i], 0);
      check("rst_mdata", m_tdata[i], 0);
    end
    @(posedge clk);
    #1 aresetn = 1;
    flush_window();
    repeat (20) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      prev = s_tready[0];
      @(negedge clk);
      check("alt_ready", s_tready[0], !prev);
      for (int i = 0; i < 2; i++) if (m_tvalid[i]) check("steady_val", m_tdata[i], 1250);
    end
    w = 0;
    while (!s_tready[0] && w < 4) begin
      @(negedge clk);
      w++;
    end
    check("flush_sync", s_tready[0], 1);
    @(posedge clk);
    #1 flush = 1;
    @(negedge clk);
    check("flush_mvalid", m_tvalid[0], 0);
    @(posedge clk);
    #1 flush = 0;
    flush_window();
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1 m_tready = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      else @(negedge clk);
      if (k >= 2) begin
        check("bp_mvalid", m_tvalid[0], 1);
        check("bp_ready", s_tready[0], 0);
        check("bp_data", m_tdata[0], 1250);
      end
    end
    @(posedge clk);
    #1 m_tready = 1;
    @(negedge clk);
    check("bp_release_mvalid", m_tvalid[0], 1);
    check("bp_release_ready", s_tready[0], 1);
    @(negedge clk);
    check("bp_after_mvalid", m_tvalid[0], 0);
    check("bp_after_ready", s_tready[0], 0);
    repeat (400) begin
      @(posedge clk);
      #1;
      s_tvalid = $urandom_range(3) != 0;
      s_tdata = DW'(int'($urandom_range(16000)) - 8000);
      m_tready = $urandom_range(2) != 0;
      flush = $urandom_range(59) == 0;
    end
    @(posedge clk);
    #1;
    flush = 0;
    s_tvalid = 1;
    s_tdata = 1000;
    m_tready = 0;
    repeat (20) @(negedge clk);
    check("hold_before_rst", m_tvalid[0], 1);
    @(posedge clk);
    #1 aresetn = 0;
    @(posedge clk);
    #1 aresetn = 1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("midrst_mvalid", m_tvalid[i], 0);
      check("midrst_mdata", m_tdata[i], 0);
      check("midrst_busy", busy[i], 1);
    end
    @(posedge clk);
    #1 m_tready = 1;
    repeat (30) @(negedge clk);
    @(posedge clk);
    #1 s_tvalid = 0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 2; i++) check("drain_empty", sb[i].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
